// File: rtl/round_sequencer.sv
// Game-level round controller: stores a new sequence, plays it, judges the player's verdict.
// Optional player response timeout is enabled by defining ROUND_TIMEOUT_EN.
module round_sequencer #(
  parameter logic [2:0] MAX_LVL     = 3'd5,
  parameter logic [1:0] START_LIVES = 2'd3,
  parameter int         STORE_CYC   = 2
`ifdef ROUND_TIMEOUT_EN
  ,
  parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       display_done,
  input  logic       correct,
  input  logic       incorrect,
  output logic       newSequence,
  output logic       disp_start,
  output logic [2:0] LVL,
  output logic [1:0] lives,
  output logic       in_play,
  output logic       game_over,
  output logic       game_won
);

  localparam int SCW = (STORE_CYC > 1) ? $clog2(STORE_CYC) : 1;
  localparam logic [SCW-1:0] STORE_LAST = SCW'(STORE_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_GEN,
    S_STORE,
    S_DISP,
    S_WAIT_DISP,
    S_INPUT,
    S_JUDGE,
    S_GAME_OVER,
    S_GAME_WON
  } state_t;

  state_t         state_q, state_d;
  logic [SCW-1:0] store_cnt_q, store_cnt_d;
  logic           pass_q, pass_d;
  logic [2:0]     lvl_q, lvl_d;
  logic [1:0]     lives_q, lives_d;
  logic           new_seq_q, disp_start_q, in_play_q, game_over_q, game_won_q;

`ifdef ROUND_TIMEOUT_EN
  logic [23:0] tmo_q, tmo_d;
  logic        tmo_expired;
  assign tmo_expired = (tmo_q == TIMEOUT_CYC - 24'd1);
`endif

  always_comb begin
    state_d     = state_q;
    store_cnt_d = store_cnt_q;
    pass_d      = pass_q;
    lvl_d       = lvl_q;
    lives_d     = lives_q;
`ifdef ROUND_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif
    case (state_q)
      S_IDLE, S_GAME_OVER, S_GAME_WON: begin
        if (start) begin
          state_d = S_GEN;
          lvl_d   = 3'd1;
          lives_d = START_LIVES;
        end
      end
      S_GEN: begin
        store_cnt_d = '0;
        state_d     = S_STORE;
      end
      S_STORE: begin
        if (store_cnt_q == STORE_LAST) state_d = S_DISP;
        else store_cnt_d = store_cnt_q + 1'b1;
      end
      S_DISP: state_d = S_WAIT_DISP;
      S_WAIT_DISP: begin
        if (display_done) begin
          state_d = S_INPUT;
`ifdef ROUND_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_INPUT: begin
        // A simultaneous correct/incorrect pair is resolved as a miss.
        if (incorrect) begin
          pass_d  = 1'b0;
          state_d = S_JUDGE;
        end else if (correct) begin
          pass_d  = 1'b1;
          state_d = S_JUDGE;
`ifdef ROUND_TIMEOUT_EN
        end else if (tmo_expired) begin
          pass_d  = 1'b0;
          state_d = S_JUDGE;
        end else begin
          tmo_d   = tmo_q + 24'd1;
`endif
        end
      end
      S_JUDGE: begin
        if (pass_q) begin
          if (lvl_q >= MAX_LVL) begin
            state_d = S_GAME_WON;
          end else begin
            lvl_d   = lvl_q + 3'd1;
            state_d = S_GEN;
          end
        end else if (lives_q <= 2'd1) begin
          lives_d = 2'd0;
          state_d = S_GAME_OVER;
        end else begin
          // Replay the sequence already held by the store block.
          lives_d = lives_q - 2'd1;
          state_d = S_DISP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      store_cnt_q  <= '0;
      pass_q       <= 1'b0;
      lvl_q        <= 3'd1;
      lives_q      <= 2'd0;
      new_seq_q    <= 1'b0;
      disp_start_q <= 1'b0;
      in_play_q    <= 1'b0;
      game_over_q  <= 1'b0;
      game_won_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_cnt_q  <= store_cnt_d;
      pass_q       <= pass_d;
      lvl_q        <= lvl_d;
      lives_q      <= lives_d;
      // Outputs decode the next state so they are registered and aligned with it.
      new_seq_q    <= (state_d == S_GEN);
      disp_start_q <= (state_d == S_DISP);
      in_play_q    <= (state_d == S_INPUT);
      game_over_q  <= (state_d == S_GAME_OVER);
      game_won_q   <= (state_d == S_GAME_WON);
    end
  end

`ifdef ROUND_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  assign newSequence = new_seq_q;
  assign disp_start  = disp_start_q;
  assign LVL         = lvl_q;
  assign lives       = lives_q;
  assign in_play     = in_play_q;
  assign game_over   = game_over_q;
  assign game_won    = game_won_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer: directed and randomized games against a game-rule model.
module tb_round_sequencer;

  localparam logic [2:0] MAX_LVL     = 3'd5;
  localparam logic [1:0] START_LIVES = 2'd3;
  localparam int         STORE_CYC   = 2;

  logic       clk = 1'b0;
  logic       rst, start, display_done, correct, incorrect;
  logic       newSequence, disp_start, in_play, game_over, game_won;
  logic [2:0] LVL;
  logic [1:0] lives;

  int checks = 0;
  int errors = 0;
  int m_lvl, m_lives;    // model: level and lives as the game rules dictate
  int outcome;           // 0 = round continues, 1 = won, 2 = over

  always #5 clk = ~clk;

  round_sequencer #(
    .MAX_LVL    (MAX_LVL),
    .START_LIVES(START_LIVES),
    .STORE_CYC  (STORE_CYC)
`ifdef ROUND_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(24'd8)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .display_done(display_done),
    .correct     (correct),
    .incorrect   (incorrect),
    .newSequence (newSequence),
    .disp_start  (disp_start),
    .LVL         (LVL),
    .lives       (lives),
    .in_play     (in_play),
    .game_over   (game_over),
    .game_won    (game_won)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_newseq"}, newSequence, 0);
    chk({tag, "_disp"}, disp_start, 0);
    chk({tag, "_lvl"}, LVL, 1);
    chk({tag, "_lives"}, lives, 0);
    chk({tag, "_inplay"}, in_play, 0);
    chk({tag, "_over"}, game_over, 0);
    chk({tag, "_won"}, game_won, 0);
  endtask

  // Called on the cycle newSequence should be high; returns on the disp_start cycle.
  task automatic expect_gen();
    chk("gen_newseq", newSequence, 1);
    chk("gen_disp", disp_start, 0);
    chk("gen_lvl", LVL, m_lvl);
    chk("gen_lives", lives, m_lives);
    for (int i = 0; i < STORE_CYC; i++) begin
      step();
      chk("store_newseq", newSequence, 0);
      chk("store_disp", disp_start, 0);
    end
    step();
    chk("disp_pulse", disp_start, 1);
    chk("disp_newseq", newSequence, 0);
  endtask

  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
    m_lvl   = 1;
    m_lives = START_LIVES;
    chk("start_over_clr", game_over, 0);
    chk("start_won_clr", game_won, 0);
    expect_gen();
  endtask

  // Starts on a disp_start cycle; plays one round with the given verdict
  // (0 correct, 1 incorrect, 2 both) and checks the result against the rules.
  task automatic run_round(input int verdict, input int delay, input bit poke, input int idle);
    bit pass;
    step();
    correct = poke;
    start   = poke;
    for (int i = 0; i < delay; i++) begin
      chk("wait_inplay", in_play, 0);
      step();
    end
    display_done = 1'b1;
    step();
    display_done = 1'b0;
    correct = 1'b0;
    start   = 1'b0;
    chk("input_inplay", in_play, 1);
    chk("input_lvl", LVL, m_lvl);
    chk("input_lives", lives, m_lives);
    for (int i = 0; i < idle; i++) step();
    chk("idle_inplay", in_play, 1);
    correct   = (verdict != 1);
    incorrect = (verdict != 0);
    step();
    correct   = 1'b0;
    incorrect = 1'b0;
    chk("judge_inplay", in_play, 0);
    chk("judge_newseq", newSequence, 0);
    pass = (verdict == 0);
    $display("round lvl=%0d lives=%0d verdict=%0d poke=%0d", m_lvl, m_lives, verdict, poke);
    step();
    if (pass && m_lvl == MAX_LVL) begin
      outcome = 1;
      chk("won_flag", game_won, 1);
      chk("won_lvl", LVL, m_lvl);
    end else if (pass) begin
      outcome = 0;
      m_lvl++;
      expect_gen();
    end else if (m_lives <= 1) begin
      outcome = 2;
      m_lives = 0;
      chk("over_flag", game_over, 1);
      chk("over_lives", lives, 0);
    end else begin
      outcome = 0;
      m_lives--;
      chk("replay_disp", disp_start, 1);
      chk("replay_newseq", newSequence, 0);
      chk("replay_lvl", LVL, m_lvl);
      chk("replay_lives", lives, m_lives);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; display_done = 1'b0; correct = 1'b0; incorrect = 1'b0;
    outcome = 0;
    repeat (3) step();
    check_reset("rst");
    rst = 1'b0;
    step();
    check_reset("idle");

    // Full win: five correct verdicts.
    start_game();
    for (int r = 0; r < 5; r++) run_round(0, $urandom_range(0, 4), 1'b0, $urandom_range(0, 3));
    chk("win_outcome", outcome, 1);
    repeat (3) step();
    chk("won_hold", game_won, 1);
    chk("won_hold_lvl", LVL, 5);

    // Pass once, then lose all lives; start from GAME_WON and GAME_OVER.
    start_game();
    run_round(0, 1, 1'b0, 0);
    run_round(1, 2, 1'b0, 1);
    run_round(1, 0, 1'b1, 2);
    run_round(2, 3, 1'b0, 0);
    chk("over_outcome", outcome, 2);
    repeat (3) step();
    chk("over_hold", game_over, 1);
    chk("over_hold_lvl", LVL, 2);

    // Both verdicts together count as a miss; then reset during WAIT_DISP.
    start_game();
    run_round(2, 1, 1'b1, 1);
    chk("both_lives", lives, 2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset("midrst");

`ifdef ROUND_TIMEOUT_EN
    // No verdict: eight INPUT cycles then a miss.
    start_game();
    step();
    display_done = 1'b1;
    step();
    display_done = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("tmo_still_input", in_play, 1);
    step();
    chk("tmo_judge", in_play, 0);
    step();
    chk("tmo_replay", disp_start, 1);
    chk("tmo_lives", lives, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif

    // Randomized games.
    for (int g = 0; g < 8; g++) begin
      start_game();
      outcome = 0;
      for (int r = 0; r < 20 && outcome == 0; r++) begin
        int v;
        v = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 2));
        run_round(v, $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
      chk("rand_end", outcome != 0, 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
